rf_write_arbiter: RTL and testbench

- Shares the single register-file write port (W, W_Adr, we) between two writeback requesters: requester 0 (ALU result) and requester 1 (memory load).
- Uses fixed priority, with requester 1 higher, plus starvation escalation for requester 0.
- Accepted writes are registered and presented to the register file one cycle later.
- Sits between the execute/memory stages and the 8x16 register file, driving its write-side inputs directly.

---
 rtl/rf_pkg.sv | 36 +++
 rtl/rf_write_arbiter_if.sv | 35 +++
 rtl/rf_starve_counter.sv | 46 ++++
 rtl/rf_write_arbiter.sv | 96 +++++++++
 tb/tb_rf_write_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Also holds the grant-selection helper used by rf_write_arbiter.
package rf_pkg;

    localparam int DATA_W   = 16;
    localparam int ADR_W    = 3;
    localparam int NUM_REGS = 8;
    localparam int CNT_W    = 3;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_ALU  = 2'b01;
    localparam logic [1:0] GNT_LD   = 2'b10;

    // Freeze blocks everything; a starving ALU request beats the load path.
    function automatic logic [1:0] arb_grant(
        input logic freeze,
        input logic at_max,
        input logic req0_valid,
        input logic req1_valid
    );
        logic [1:0] gnt;
        if (freeze) begin
            gnt = GNT_NONE;
        end else if (req0_valid && at_max) begin
            gnt = GNT_ALU;
        end else if (req1_valid) begin
            gnt = GNT_LD;
        end else if (req0_valid) begin
            gnt = GNT_ALU;
        end else begin
            gnt = GNT_NONE;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Write-request and register-file write-port bundle for rf_write_arbiter.
// master: the pipeline/register-file side; slave: the arbiter.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic              freeze;
    logic              req0_valid;
    logic              req0_ready;
    logic [ADR_W-1:0]  req0_adr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADR_W-1:0]  req1_adr;
    logic [DATA_W-1:0] req1_data;
    logic [DATA_W-1:0] W;
    logic [ADR_W-1:0]  W_Adr;
    logic              we;
    logic              starve_evt;

    modport slave (
        input  freeze,
        input  req0_valid, req0_adr, req0_data,
        input  req1_valid, req1_adr, req1_data,
        output req0_ready, req1_ready,
        output W, W_Adr, we, starve_evt
    );

    modport master (
        output freeze,
        output req0_valid, req0_adr, req0_data,
        output req1_valid, req1_adr, req1_data,
        input  req0_ready, req1_ready,
        input  W, W_Adr, we, starve_evt
    );
endinterface

// File: rtl/rf_starve_counter.sv
// Counts consecutive cycles an ALU write request is denied; flags when the
// count reaches MAX_WAIT so the arbiter can force-grant the ALU.
module rf_starve_counter
    import rf_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freeze,
    input  logic             req0_valid,
    input  logic             req0_gnt,
    output logic             at_max,
    output logic [CNT_W-1:0] wait_cnt
);

    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_nxt_s;

    // Next count: freeze holds, grant or idle clears, denial saturates upward.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (freeze) begin
            wait_cnt_nxt_s = wait_cnt_r;
        end else if (!req0_valid || req0_gnt) begin
            wait_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (wait_cnt_r < CNT_W'(MAX_WAIT)) begin
            wait_cnt_nxt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    assign at_max   = (wait_cnt_r == CNT_W'(MAX_WAIT));
    assign wait_cnt = wait_cnt_r;

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write-port arbiter (load over ALU, with ALU
// starvation escalation) and one-cycle registered write stage.
// Optional: define RF_ZERO_REG_EN to suppress writes to register 0.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    rf_write_arbiter_if.slave  bus
);

    logic [1:0]        gnt_s;
    logic              at_max_s;
    logic [CNT_W-1:0]  wait_cnt_s;
    logic              forced_s;
    logic              accept_s;
    logic              we_nxt_s;
    logic [DATA_W-1:0] w_nxt_s;
    logic [ADR_W-1:0]  w_adr_nxt_s;

    logic [DATA_W-1:0] w_r;
    logic [ADR_W-1:0]  w_adr_r;
    logic              we_r;
    logic              starve_evt_r;

    rf_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .freeze     (bus.freeze),
        .req0_valid (bus.req0_valid),
        .req0_gnt   (gnt_s == GNT_ALU),
        .at_max     (at_max_s),
        .wait_cnt   (wait_cnt_s)
    );

    assign gnt_s          = arb_grant(bus.freeze, at_max_s, bus.req0_valid, bus.req1_valid);
    assign bus.req0_ready = (gnt_s == GNT_ALU);
    assign bus.req1_ready = (gnt_s == GNT_LD);
    assign forced_s       = (gnt_s == GNT_ALU) && at_max_s;

    // Select the granted requester's payload for the write register.
    always_comb begin
        accept_s    = 1'b0;
        w_nxt_s     = w_r;
        w_adr_nxt_s = w_adr_r;
        case (gnt_s)
            GNT_ALU: begin
                accept_s    = 1'b1;
                w_nxt_s     = bus.req0_data;
                w_adr_nxt_s = bus.req0_adr;
            end
            GNT_LD: begin
                accept_s    = 1'b1;
                w_nxt_s     = bus.req1_data;
                w_adr_nxt_s = bus.req1_adr;
            end
            default: begin
                accept_s    = 1'b0;
                w_nxt_s     = w_r;
                w_adr_nxt_s = w_adr_r;
            end
        endcase
    end

`ifdef RF_ZERO_REG_EN
    // R0 is hard-wired zero: the request is consumed but never written.
    assign we_nxt_s = accept_s && (w_adr_nxt_s != {ADR_W{1'b0}});
`else
    assign we_nxt_s = accept_s;
`endif

    // Write-port output register; reset drops any write still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_r          <= {DATA_W{1'b0}};
            w_adr_r      <= {ADR_W{1'b0}};
            we_r         <= 1'b0;
            starve_evt_r <= 1'b0;
        end else begin
            w_r          <= w_nxt_s;
            w_adr_r      <= w_adr_nxt_s;
            we_r         <= we_nxt_s;
            starve_evt_r <= forced_s;
        end
    end

    assign bus.W          = w_r;
    assign bus.W_Adr      = w_adr_r;
    assign bus.we         = we_r;
    assign bus.starve_evt = starve_evt_r;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (MAX_WAIT=4): reset, single write,
// back-to-back, starvation, freeze, register-0 write, reset in flight.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(
        .MAX_WAIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.freeze     = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_adr   = 3'd0;
        bus.req0_data  = 16'h0000;
        bus.req1_valid = 1'b0;
        bus.req1_adr   = 3'd0;
        bus.req1_data  = 16'h0000;

        // Reset state
        tick();
        tick();
        check("rst_we",     {31'd0, bus.we},         32'd0);
        check("rst_W",      {16'd0, bus.W},          32'd0);
        check("rst_W_Adr",  {29'd0, bus.W_Adr},      32'd0);
        check("rst_starve", {31'd0, bus.starve_evt}, 32'd0);
        check("rst_cnt",    {29'd0, dut.wait_cnt_s}, 32'd0);
        reset = 1'b0;
        tick();

        // Single ALU request
        bus.req0_valid = 1'b1;
        bus.req0_adr   = 3'd5;
        bus.req0_data  = 16'h1234;
        #1;
        check("single_rdy0", {31'd0, bus.req0_ready}, 32'd1);
        check("single_rdy1", {31'd0, bus.req1_ready}, 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        check("single_we",  {31'd0, bus.we},    32'd1);
        check("single_adr", {29'd0, bus.W_Adr}, 32'd5);
        check("single_W",   {16'd0, bus.W},     32'h1234);
        tick();
        check("single_we_off", {31'd0, bus.we}, 32'd0);
        check("single_W_hold", {16'd0, bus.W},  32'h1234);

        // Back-to-back load writes to registers 1, 2, 3
        for (int i = 1; i <= 3; i++) begin
            bus.req1_valid = 1'b1;
            bus.req1_adr   = 3'(i);
            bus.req1_data  = 16'hA000 + 16'(i);
            #1;
            check("b2b_rdy1", {31'd0, bus.req1_ready}, 32'd1);
            tick();
            check("b2b_we",  {31'd0, bus.we},    32'd1);
            check("b2b_adr", {29'd0, bus.W_Adr}, 32'(i));
            check("b2b_W",   {16'd0, bus.W},     32'hA000 + 32'(i));
        end
        bus.req1_valid = 1'b0;
        tick();
        check("b2b_we_off", {31'd0, bus.we}, 32'd0);

        // Starvation: both requesters continuously valid
        bus.req0_valid = 1'b1;
        bus.req0_adr   = 3'd6;
        bus.req0_data  = 16'h0A0A;
        bus.req1_valid = 1'b1;
        bus.req1_adr   = 3'd7;
        bus.req1_data  = 16'h1B1B;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("stv_rdy0", {31'd0, bus.req0_ready}, (c == 4) ? 32'd1 : 32'd0);
            check("stv_rdy1", {31'd0, bus.req1_ready}, (c == 4) ? 32'd0 : 32'd1);
            tick();
            check("stv_evt", {31'd0, bus.starve_evt}, (c == 4) ? 32'd1 : 32'd0);
            check("stv_we",  {31'd0, bus.we},         32'd1);
            check("stv_W",   {16'd0, bus.W},          (c == 4) ? 32'h0A0A : 32'h1B1B);
            check("stv_adr", {29'd0, bus.W_Adr},      (c == 4) ? 32'd6 : 32'd7);
            check("stv_cnt", {29'd0, dut.wait_cnt_s},
                  (c < 4) ? 32'(c + 1) : ((c == 4) ? 32'd0 : 32'(c - 4)));
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        check("idle_cnt", {29'd0, dut.wait_cnt_s}, 32'd0);

        // Freeze: build wait_cnt to 2, then hold for 3 frozen cycles
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        tick();
        check("frz_pre_cnt", {29'd0, dut.wait_cnt_s}, 32'd2);
        bus.freeze = 1'b1;
        #1;
        check("frz_inflight_we", {31'd0, bus.we}, 32'd1);
        for (int f = 0; f < 3; f++) begin
            check("frz_rdy0", {31'd0, bus.req0_ready}, 32'd0);
            check("frz_rdy1", {31'd0, bus.req1_ready}, 32'd0);
            tick();
            check("frz_cnt", {29'd0, dut.wait_cnt_s}, 32'd2);
            check("frz_we",  {31'd0, bus.we},         32'd0);
        end
        bus.freeze = 1'b0;
        #1;
        check("unfrz_rdy1", {31'd0, bus.req1_ready}, 32'd1);
        check("unfrz_rdy0", {31'd0, bus.req0_ready}, 32'd0);
        tick();
        check("unfrz_we",  {31'd0, bus.we},         32'd1);
        check("unfrz_W",   {16'd0, bus.W},          32'h1B1B);
        check("unfrz_cnt", {29'd0, dut.wait_cnt_s}, 32'd3);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // ALU write to register 0
        bus.req0_valid = 1'b1;
        bus.req0_adr   = 3'd0;
        bus.req0_data  = 16'hFFFF;
        #1;
        check("r0_rdy0", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
`ifdef RF_ZERO_REG_EN
        check("r0_we", {31'd0, bus.we}, 32'd0);
`else
        check("r0_we",  {31'd0, bus.we},    32'd1);
        check("r0_adr", {29'd0, bus.W_Adr}, 32'd0);
        check("r0_W",   {16'd0, bus.W},     32'hFFFF);
`endif
        tick();

        // Reset while a load write sits in the output register
        bus.req1_valid = 1'b1;
        bus.req1_adr   = 3'd3;
        bus.req1_data  = 16'hBEEF;
        #1;
        check("rstmid_rdy1", {31'd0, bus.req1_ready}, 32'd1);
        @(posedge clk);
        reset = 1'b1;
        bus.req1_valid = 1'b0;
        #1;
        check("rstmid_we",  {31'd0, bus.we},    32'd0);
        check("rstmid_W",   {16'd0, bus.W},     32'd0);
        check("rstmid_adr", {29'd0, bus.W_Adr}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rstmid_we_after", {31'd0, bus.we}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
